// File: rtl/sum_pkg.sv
// Shared types for the sum stream scheduler: FSM state encoding and default widths.
// No logic, so no latency or backpressure.
package sum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int DEF_NOF_BITS = 32;
    localparam int DEF_LEN_W    = 16;

endpackage

// File: rtl/sum_stream_sched_rr_arbiter.sv
// Round-robin pick among NUM_CH requests, searching upward from ptr with wrap.
// Purely combinational (zero latency); holds no state and applies no backpressure.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sum_stream_sched.sv
// Frame round-robin scheduler feeding one sum datapath; beat->sum_* 1 cycle, last beat->res_valid 3 cycles.
// Grants stall while the result buffer is full and unconsumed; optional res_len under SUM_STREAM_SCHED_LEN_EN.
module sum_stream_sched
    import sum_pkg::*;
#(
    parameter int NOF_BITS = DEF_NOF_BITS,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = $clog2(NUM_CH),
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          s_valid,
    output logic [NUM_CH-1:0]          s_ready,
    input  logic [NUM_CH-1:0]          s_first,
    input  logic [NUM_CH-1:0]          s_last,
    input  logic [NUM_CH*NOF_BITS-1:0] s_data,
    output logic                       sum_first,
    output logic                       sum_last,
    output logic [NOF_BITS-1:0]        sum_data,
    input  logic                       sum_done,
    input  logic [NOF_BITS:0]          sum_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NOF_BITS:0]          res_sum,
    output logic [CH_W-1:0]            res_ch,
`ifdef SUM_STREAM_SCHED_LEN_EN
    output logic [LEN_W-1:0]           res_len,
`endif
    output logic                       drop_pulse,
    output logic                       dp_active
);

    state_t              state, state_nxt;
    logic [CH_W-1:0]     gnt, rr_ptr, ptr_nxt;
    logic [NUM_CH-1:0]   req, arb_oh;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_any, do_grant, accept;
    logic                sel_valid, sel_first, sel_last;
    logic [NOF_BITS-1:0] sel_data;

    assign req = s_valid & s_first;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // A full result buffer only blocks a grant if it is not drained this same cycle.
    assign do_grant  = (state == IDLE) && arb_any && (!res_valid || res_ready);
    assign sel_valid = s_valid[gnt];
    assign sel_first = s_first[gnt];
    assign sel_last  = s_last[gnt];
    assign sel_data  = s_data[int'(gnt)*NOF_BITS +: NOF_BITS];
    assign accept    = (state == STREAM) && sel_valid;
    assign ptr_nxt   = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_grant) state_nxt = STREAM;
            STREAM:  if (accept && sel_last) state_nxt = WAIT;
            WAIT:    if (sum_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE, non-first beats are acked and discarded so a stale tail cannot wedge a channel.
    always_comb begin
        s_ready    = '0;
        drop_pulse = 1'b0;
        dp_active  = 1'b0;
        case (state)
            IDLE: begin
                s_ready    = s_valid & ~s_first;
                drop_pulse = |(s_valid & ~s_first);
            end
            STREAM: begin
                s_ready[gnt] = 1'b1;
                dp_active    = 1'b1;
            end
            WAIT:    dp_active = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rr_ptr    <= '0;
            sum_data  <= '0;
            sum_first <= 1'b0;
            sum_last  <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_ch    <= '0;
        end else begin
            if (do_grant) gnt <= arb_idx;
            // Zero-fill bubbles: the datapath accumulates every busy cycle.
            sum_data  <= accept ? sel_data : '0;
            sum_first <= accept && sel_first;
            sum_last  <= accept && sel_last;
            if (state == WAIT && sum_done) begin
                res_valid <= 1'b1;
                res_sum   <= sum_result;
                res_ch    <= gnt;
                rr_ptr    <= ptr_nxt;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SUM_STREAM_SCHED_LEN_EN
    logic [LEN_W-1:0] len_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
            res_len <= '0;
        end else begin
            if (accept) begin
                if (sel_first)     len_cnt <= LEN_W'(1);
                else if (~&len_cnt) len_cnt <= len_cnt + 1'b1;
            end
            if (state == WAIT && sum_done) res_len <= len_cnt;
        end
    end
`endif

endmodule
